// File: rtl/rom_fetch_ctrl.sv
// ============================================================================
// rom_fetch_ctrl
// ----------------------------------------------------------------------------
// Instruction fetch sequencer for the CPU program ROM.
//
// This block owns the program counter and drives the ROM address directly
// from it. The ROM has an asynchronous read, so the word for the current pc
// is available in the same cycle. That word is captured into a one-entry
// instruction slot, which decode/execute takes over a valid/ready handshake.
// Execute can redirect the fetch stream with a jump pulse, or stop it for
// good with a halt. Only a reset brings the controller back out of halt.
//
// Parameters
//   ADDR_W    ROM address width and pc width; the pc wraps modulo 2**ADDR_W
//   DATA_W    instruction word width
//   RESET_PC  pc value loaded at reset
//
// Ports
//   clk        in   1       single clock, all state on posedge
//   rst        in   1       synchronous, active-high reset
//   rom_addr   out  ADDR_W  ROM address, combinational copy of pc
//   rom_dout   in   DATA_W  ROM read data for rom_addr, same cycle
//   ins_valid  out  1       instruction slot holds a valid word
//   ins_ready  in   1       consumer accepts the slot this cycle
//   ins_data   out  DATA_W  registered instruction word
//   ins_pc     out  ADDR_W  address ins_data was fetched from
//   jmp_en     in   1       one-cycle redirect pulse from execute
//   jmp_addr   in   ADDR_W  redirect target, sampled when jmp_en=1
//   halt       in   1       stop fetching; sticky until rst
//   halted     out  1       controller is in HALT
// ============================================================================
module rom_fetch_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 37,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [DATA_W-1:0] ins_data,
    output logic [ADDR_W-1:0] ins_pc,
    input  logic              jmp_en,
    input  logic [ADDR_W-1:0] jmp_addr,
    input  logic              halt,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HALT  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_n;
    logic              valid_n;
    logic [DATA_W-1:0] data_n;
    logic [ADDR_W-1:0] ins_pc_n;
    logic              slot_free;

    // The ROM sees the pc directly; there is no registered address stage,
    // so the word returned this cycle always belongs to the current pc.
    assign rom_addr = pc;

    // halted is simply the decoded state register, so it changes only on
    // a clock edge and never depends combinationally on the inputs.
    assign halted = (state == S_HALT);

    // The slot can take a new word if it is empty, or if the consumer is
    // draining it on this very edge.
    assign slot_free = !ins_valid || ins_ready;

    // Next-state and datapath decisions. Within FETCH, halt beats jump and
    // jump beats a normal fetch. A jump squashes whatever sits in the slot,
    // because that word came from the wrong path; the redirected word is
    // fetched on the following edge, which gives the single-cycle bubble.
    // When the slot is full and not being accepted, everything holds so
    // the consumer sees a stable word and the pc does not run ahead.
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        valid_n  = ins_valid;
        data_n   = ins_data;
        ins_pc_n = ins_pc;

        case (state)
            S_FETCH: begin
                if (halt) begin
                    state_n = S_HALT;
                    valid_n = 1'b0;
                end else if (jmp_en) begin
                    valid_n = 1'b0;
                    pc_n    = jmp_addr;
                end else if (slot_free) begin
                    data_n   = rom_dout;
                    ins_pc_n = pc;
                    valid_n  = 1'b1;
                    pc_n     = pc + PC_STEP;
                end
            end
            S_HALT: begin
                valid_n = 1'b0;
            end
        endcase
    end

    // State register. Reset discards any in-flight slot and restarts the
    // fetch stream from RESET_PC, whether or not the controller was halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            pc        <= PC_INIT;
            ins_valid <= 1'b0;
            ins_data  <= '0;
            ins_pc    <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            ins_valid <= valid_n;
            ins_data  <= data_n;
            ins_pc    <= ins_pc_n;
        end
    end

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// ============================================================================
// tb_rom_fetch_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for rom_fetch_ctrl. A behavioural ROM with random
// contents answers rom_addr combinationally. Directed scenarios cover reset,
// backpressure, jump, wrap, halt priority and mid-stream reset. A randomized
// run is then checked cycle by cycle against a small reference model that
// tracks the pc, the slot contents and the halt flag.
// Inputs are driven on the falling edge and outputs are observed on the
// falling edge after the next rising edge.
// ============================================================================
module tb_rom_fetch_ctrl;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 37;
    localparam int RESET_PC = 0;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_dout;
    logic              ins_valid;
    logic              ins_ready;
    logic [DATA_W-1:0] ins_data;
    logic [ADDR_W-1:0] ins_pc;
    logic              jmp_en;
    logic [ADDR_W-1:0] jmp_addr;
    logic              halt;
    logic              halted;

    logic [DATA_W-1:0] rom [256];

    int vectors;
    int miscompares;

    rom_fetch_ctrl #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .ins_data  (ins_data),
        .ins_pc    (ins_pc),
        .jmp_en    (jmp_en),
        .jmp_addr  (jmp_addr),
        .halt      (halt),
        .halted    (halted)
    );

    // Asynchronous-read ROM model.
    assign rom_dout = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and come back to the falling edge to observe.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Assert reset for one edge and release it; the caller decides how
    // many further cycles to run.
    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    // Reset values, then the first four words stream out back to back.
    task automatic test_reset();
        rst = 1'b1; ins_ready = 1'b1; jmp_en = 1'b0; jmp_addr = '0; halt = 1'b0;
        cycle();
        vectors++;
        if (ins_valid !== 1'b0 || ins_data !== '0 || ins_pc !== '0 ||
            halted !== 1'b0 || rom_addr !== ADDR_W'(RESET_PC)) begin
            miscompares++;
            $display("[TB] FAIL reset_values got v=%0b d=%h pc=%h h=%0b a=%h want v=0 d=0 pc=0 h=0 a=%h",
                     ins_valid, ins_data, ins_pc, halted, rom_addr, ADDR_W'(RESET_PC));
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            vectors++;
            if (ins_valid !== 1'b1 || ins_pc !== ADDR_W'(i) || ins_data !== rom[i]) begin
                miscompares++;
                $display("[TB] FAIL reset_stream[%0d] got v=%0b pc=%h d=%h want v=1 pc=%h d=%h",
                         i, ins_valid, ins_pc, ins_data, ADDR_W'(i), rom[i]);
            end
        end
    endtask

    // Hold (1,B) for three cycles with ready low, then resume with (2,C).
    task automatic test_backpressure();
        ins_ready = 1'b1;
        do_reset();
        cycle();
        cycle();
        ins_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            vectors++;
            if (ins_valid !== 1'b1 || ins_pc !== 8'd1 || ins_data !== rom[1] || rom_addr !== 8'd2) begin
                miscompares++;
                $display("[TB] FAIL backpressure_hold[%0d] got v=%0b pc=%h d=%h a=%h want v=1 pc=01 d=%h a=02",
                         i, ins_valid, ins_pc, ins_data, rom_addr, rom[1]);
            end
        end
        ins_ready = 1'b1;
        for (int i = 2; i < 4; i++) begin
            cycle();
            vectors++;
            if (ins_valid !== 1'b1 || ins_pc !== ADDR_W'(i) || ins_data !== rom[i]) begin
                miscompares++;
                $display("[TB] FAIL backpressure_resume got v=%0b pc=%h d=%h want v=1 pc=%h d=%h",
                         ins_valid, ins_pc, ins_data, ADDR_W'(i), rom[i]);
            end
        end
    endtask

    // Jump to 0x40 while the slot holds pc 5: one bubble, then the target.
    task automatic test_jump();
        ins_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) cycle();
        vectors++;
        if (ins_valid !== 1'b1 || ins_pc !== 8'd5) begin
            miscompares++;
            $display("[TB] FAIL jump_setup got v=%0b pc=%h want v=1 pc=05", ins_valid, ins_pc);
        end
        jmp_en = 1'b1; jmp_addr = 8'h40;
        cycle();
        jmp_en = 1'b0; jmp_addr = '0;
        vectors++;
        if (ins_valid !== 1'b0 || ins_pc !== 8'd5 || rom_addr !== 8'h40) begin
            miscompares++;
            $display("[TB] FAIL jump_bubble got v=%0b pc=%h a=%h want v=0 pc=05 a=40",
                     ins_valid, ins_pc, rom_addr);
        end
        for (int i = 0; i < 2; i++) begin
            cycle();
            vectors++;
            if (ins_valid !== 1'b1 || ins_pc !== ADDR_W'(8'h40 + i) || ins_data !== rom[8'h40 + i]) begin
                miscompares++;
                $display("[TB] FAIL jump_target[%0d] got v=%0b pc=%h d=%h want v=1 pc=%h d=%h",
                         i, ins_valid, ins_pc, ins_data, ADDR_W'(8'h40 + i), rom[8'h40 + i]);
            end
        end
    endtask

    // Jump near the top of the address space and watch the pc wrap.
    task automatic test_wrap();
        logic [ADDR_W-1:0] expPc;
        ins_ready = 1'b1;
        jmp_en = 1'b1; jmp_addr = 8'hFE;
        cycle();
        jmp_en = 1'b0; jmp_addr = '0;
        vectors++;
        if (ins_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wrap_bubble got v=%0b want v=0", ins_valid);
        end
        expPc = 8'hFE;
        for (int i = 0; i < 4; i++) begin
            cycle();
            vectors++;
            if (ins_valid !== 1'b1 || ins_pc !== expPc || ins_data !== rom[expPc]) begin
                miscompares++;
                $display("[TB] FAIL wrap_seq[%0d] got v=%0b pc=%h d=%h want v=1 pc=%h d=%h",
                         i, ins_valid, ins_pc, ins_data, expPc, rom[expPc]);
            end
            expPc = expPc + 8'd1;
        end
    endtask

    // halt and jmp_en together: halt wins, the pc is not redirected, and
    // nothing but reset gets the controller out again.
    task automatic test_halt_priority();
        ins_ready = 1'b1;
        do_reset();
        cycle();
        cycle();
        cycle();
        halt = 1'b1; jmp_en = 1'b1; jmp_addr = 8'h77;
        cycle();
        halt = 1'b0; jmp_en = 1'b0; jmp_addr = '0;
        vectors++;
        if (halted !== 1'b1 || ins_valid !== 1'b0 || rom_addr !== 8'd3) begin
            miscompares++;
            $display("[TB] FAIL halt_entry got h=%0b v=%0b a=%h want h=1 v=0 a=03",
                     halted, ins_valid, rom_addr);
        end
        for (int i = 0; i < 20; i++) begin
            ins_ready = 1'($urandom_range(0, 1));
            jmp_en    = 1'($urandom_range(0, 1));
            halt      = 1'($urandom_range(0, 1));
            jmp_addr  = 8'($urandom_range(0, 255));
            cycle();
            vectors++;
            if (halted !== 1'b1 || ins_valid !== 1'b0 || rom_addr !== 8'd3) begin
                miscompares++;
                $display("[TB] FAIL halt_sticky[%0d] got h=%0b v=%0b a=%h want h=1 v=0 a=03",
                         i, halted, ins_valid, rom_addr);
            end
        end
        vectors++;
        if (ins_pc !== 8'd2 || ins_data !== rom[2]) begin
            miscompares++;
            $display("[TB] FAIL halt_slot_hold got pc=%h d=%h want pc=02 d=%h", ins_pc, ins_data, rom[2]);
        end
        halt = 1'b0; jmp_en = 1'b0; jmp_addr = '0; ins_ready = 1'b1;
        do_reset();
        cycle();
        vectors++;
        if (halted !== 1'b0 || ins_valid !== 1'b1 || ins_pc !== 8'd0 || ins_data !== rom[0]) begin
            miscompares++;
            $display("[TB] FAIL halt_exit got h=%0b v=%0b pc=%h d=%h want h=0 v=1 pc=00 d=%h",
                     halted, ins_valid, ins_pc, ins_data, rom[0]);
        end
    endtask

    // Reset while a word waits in the slot: it must vanish immediately.
    task automatic test_reset_midstream();
        ins_ready = 1'b1;
        do_reset();
        cycle();
        cycle();
        ins_ready = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        vectors++;
        if (ins_valid !== 1'b0 || ins_data !== '0 || ins_pc !== '0 ||
            halted !== 1'b0 || rom_addr !== ADDR_W'(RESET_PC)) begin
            miscompares++;
            $display("[TB] FAIL midreset_values got v=%0b d=%h pc=%h h=%0b a=%h want v=0 d=0 pc=0 h=0 a=%h",
                     ins_valid, ins_data, ins_pc, halted, rom_addr, ADDR_W'(RESET_PC));
        end
        rst = 1'b0; ins_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            vectors++;
            if (ins_valid !== 1'b1 || ins_pc !== ADDR_W'(i) || ins_data !== rom[i]) begin
                miscompares++;
                $display("[TB] FAIL midreset_restart[%0d] got v=%0b pc=%h d=%h want v=1 pc=%h d=%h",
                         i, ins_valid, ins_pc, ins_data, ADDR_W'(i), rom[i]);
            end
        end
    endtask

    // Randomized traffic against a reference model. The model keeps the
    // next fetch address, which word the slot should hold, and whether
    // the controller has been halted, and applies the documented per-edge
    // rules to them.
    task automatic test_random();
        logic              mHalted;
        logic              mValid;
        logic [ADDR_W-1:0] mPc;
        logic [ADDR_W-1:0] mSlotPc;
        logic [DATA_W-1:0] mData;
        mHalted = 1'b0; mValid = 1'b0; mPc = '0; mSlotPc = '0; mData = '0;
        for (int i = 0; i < 600; i++) begin
            rst       = (i == 0) || ($urandom_range(0, 59) == 0);
            ins_ready = ($urandom_range(0, 3) != 0);
            jmp_en    = ($urandom_range(0, 9) == 0);
            jmp_addr  = 8'($urandom_range(0, 255));
            halt      = ($urandom_range(0, 119) == 0);

            if (rst) begin
                mHalted = 1'b0; mValid = 1'b0; mPc = ADDR_W'(RESET_PC);
                mSlotPc = '0; mData = '0;
            end else if (mHalted) begin
                mValid = 1'b0;
            end else if (halt) begin
                mHalted = 1'b1; mValid = 1'b0;
            end else if (jmp_en) begin
                mValid = 1'b0; mPc = jmp_addr;
            end else if (!mValid || ins_ready) begin
                mData = rom[mPc]; mSlotPc = mPc; mValid = 1'b1; mPc = mPc + 8'd1;
            end

            cycle();
            vectors++;
            if (ins_valid !== mValid || halted !== mHalted || rom_addr !== mPc ||
                ins_pc !== mSlotPc || ins_data !== mData) begin
                miscompares++;
                $display("[TB] FAIL random[%0d] got v=%0b h=%0b a=%h pc=%h d=%h want v=%0b h=%0b a=%h pc=%h d=%h",
                         i, ins_valid, halted, rom_addr, ins_pc, ins_data,
                         mValid, mHalted, mPc, mSlotPc, mData);
            end
        end
        rst = 1'b0; jmp_en = 1'b0; halt = 1'b0; ins_ready = 1'b1;
    endtask

    initial begin
        logic [63:0] w;
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; ins_ready = 1'b0; jmp_en = 1'b0; jmp_addr = '0; halt = 1'b0;
        for (int i = 0; i < 256; i++) begin
            w = {$urandom(), $urandom()};
            rom[i] = w[DATA_W-1:0];
        end
        @(negedge clk);

        test_reset();
        test_backpressure();
        test_jump();
        test_wrap();
        test_halt_priority();
        test_reset_midstream();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
